// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: holds one EX entry, waits for the data-SRAM response of loads,
// extracts/extends load data and hands the result to WB, with flush-safe response tracking.
module mem_stage_lsu #(
   parameter int DATA_W      = 32,
   parameter int ES_TO_MS_WD = DATA_W + 44,
   parameter int MS_TO_WS_WD = DATA_W + 38
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   ws_allowin,
   output logic                   ms_allowin,
   input  logic                   es_to_ms_valid,
   input  logic [ES_TO_MS_WD-1:0] es_to_ms_bus,
   input  logic                   flush,
   input  logic                   data_sram_data_ok,
   input  logic [DATA_W-1:0]      data_sram_rdata,
   output logic                   ms_to_ws_valid,
   output logic [MS_TO_WS_WD-1:0] ms_to_ws_bus,
   output logic [DATA_W+6:0]      ms_fwd_bus
);

   localparam int OFF_W   = (DATA_W == 64) ? 3 : 2;
   localparam int ALU_LO  = 32;
   localparam int DEST_LO = DATA_W + 32;
   localparam int WE_B    = DATA_W + 37;
   localparam int SIGN_B  = DATA_W + 38;
   localparam int SIZE_LO = DATA_W + 39;
   localparam int LDEN_B  = DATA_W + 41;
   localparam int MREQ_B  = DATA_W + 42;

   typedef enum logic {
      ST_HAVE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   logic                   ms_valid_q, ms_valid_d;
   state_t                 state_q, state_d;
   logic [1:0]             discard_q, discard_d;
   logic [DATA_W-1:0]      buf_q, buf_d;
   logic [ES_TO_MS_WD-2:0] bus_q, bus_d;

   logic                   spare_unused;
   logic [31:0]            pc;
   logic [DATA_W-1:0]      alu_result;
   logic [4:0]             dest;
   logic                   gr_we, ld_sign, ld_en, mem_req;
   logic [1:0]             ld_size;

   logic                   rsp_take, discard_dec, discard_inc;
   logic                   ms_ready_go, accept;
   logic                   fwd_valid, fwd_busy;
   logic [DATA_W-1:0]      ld_src, ld_shift, ld_data, final_result;
   logic                   ld_msb;
   int unsigned            ld_bits;

   assign spare_unused = es_to_ms_bus[ES_TO_MS_WD-1];

   assign pc         = bus_q[31:0];
   assign alu_result = bus_q[ALU_LO +: DATA_W];
   assign dest       = bus_q[DEST_LO +: 5];
   assign gr_we      = bus_q[WE_B];
   assign ld_sign    = bus_q[SIGN_B];
   assign ld_size    = bus_q[SIZE_LO +: 2];
   assign ld_en      = bus_q[LDEN_B];
   assign mem_req    = bus_q[MREQ_B];

   // A response only belongs to the held entry once every cancelled request has drained.
   assign rsp_take    = data_sram_data_ok && (discard_q == 2'd0) && ms_valid_q && (state_q == ST_WAIT);
   assign discard_dec = data_sram_data_ok && (discard_q != 2'd0);
   assign discard_inc = flush && ms_valid_q && (state_q == ST_WAIT) && !rsp_take;

   assign ms_ready_go    = !mem_req || (state_q == ST_HAVE) || rsp_take;
   assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
   assign accept         = es_to_ms_valid && ms_allowin && !flush;
   assign ms_to_ws_valid = ms_valid_q && ms_ready_go && !flush;

   always_comb begin
      ld_src   = (state_q == ST_HAVE) ? buf_q : data_sram_rdata;
      ld_shift = ld_src >> {alu_result[OFF_W-1:0], 3'b000};
      case (ld_size)
         2'b00: begin
            ld_bits = 32'd8;
            ld_msb  = ld_shift[7];
         end
         2'b01: begin
            ld_bits = 32'd16;
            ld_msb  = ld_shift[15];
         end
         2'b10: begin
            ld_bits = 32'd32;
            ld_msb  = ld_shift[31];
         end
         default: begin
            // dword on a 64-bit datapath; on 32-bit this is the full word
            ld_bits = DATA_W;
            ld_msb  = ld_shift[DATA_W-1];
         end
      endcase
      ld_data = '0;
      for (int unsigned i = 0; i < DATA_W; i++) begin
         ld_data[i] = (i < ld_bits) ? ld_shift[i] : (ld_sign & ld_msb);
      end
      final_result = ld_en ? ld_data : alu_result;
   end

   assign fwd_valid    = ms_valid_q && gr_we;
   assign fwd_busy     = fwd_valid && ld_en && !ms_ready_go;
   assign ms_to_ws_bus = {gr_we, dest, final_result, pc};
   assign ms_fwd_bus   = {fwd_valid, fwd_busy, dest, final_result};

   always_comb begin
      ms_valid_d = ms_valid_q;
      state_d    = state_q;
      discard_d  = discard_q + {1'b0, discard_inc} - {1'b0, discard_dec};
      buf_d      = buf_q;
      bus_d      = bus_q;
      if (rsp_take) begin
         state_d = ST_HAVE;
         if (!ws_allowin && !flush) begin
            buf_d = data_sram_rdata;
         end
      end
      if (flush) begin
         ms_valid_d = 1'b0;
         state_d    = ST_HAVE;
      end else if (ms_allowin) begin
         ms_valid_d = es_to_ms_valid;
         if (accept) begin
            bus_d   = es_to_ms_bus[ES_TO_MS_WD-2:0];
            state_d = es_to_ms_bus[MREQ_B] ? ST_WAIT : ST_HAVE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ms_valid_q <= 1'b0;
         state_q    <= ST_HAVE;
         discard_q  <= '0;
         buf_q      <= '0;
         bus_q      <= '0;
      end else begin
         ms_valid_q <= ms_valid_d;
         state_q    <= state_d;
         discard_q  <= discard_d;
         buf_q      <= buf_d;
         bus_q      <= bus_d;
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: identical stimulus drives a 32-bit and a 64-bit instance,
// expectations come from a transaction-level model of entries and outstanding responses.
module tb_mem_stage_lsu;

   logic         clk;
   logic         reset;
   logic         ws_allowin;
   logic         es_to_ms_valid;
   logic [75:0]  es_bus32;
   logic [107:0] es_bus64;
   logic         flush;
   logic         data_ok;
   logic [63:0]  rdata64;
   logic [31:0]  rdata32;
   logic         allowin32, allowin64;
   logic         valid32, valid64;
   logic [69:0]  ws_bus32;
   logic [101:0] ws_bus64;
   logic [38:0]  fwd32;
   logic [70:0]  fwd64;

   assign rdata32 = rdata64[31:0];

   mem_stage_lsu #(.DATA_W(32)) u_dut32 (
      .clk(clk), .reset(reset), .ws_allowin(ws_allowin), .ms_allowin(allowin32),
      .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_bus32), .flush(flush),
      .data_sram_data_ok(data_ok), .data_sram_rdata(rdata32),
      .ms_to_ws_valid(valid32), .ms_to_ws_bus(ws_bus32), .ms_fwd_bus(fwd32)
   );

   mem_stage_lsu #(.DATA_W(64)) u_dut64 (
      .clk(clk), .reset(reset), .ws_allowin(ws_allowin), .ms_allowin(allowin64),
      .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_bus64), .flush(flush),
      .data_sram_data_ok(data_ok), .data_sram_rdata(rdata64),
      .ms_to_ws_valid(valid64), .ms_to_ws_bus(ws_bus64), .ms_fwd_bus(fwd64)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] data;
      logic        cancelled;
   } resp_t;

   resp_t        resp_q[$];
   logic [69:0]  q32[$];
   logic [101:0] q64[$];

   int n_cmp = 0;
   int n_bad = 0;

   // pending EX offer
   logic        e_valid, e_mreq, e_ld, e_sg, e_we, e_spare;
   logic [1:0]  e_sz;
   logic [4:0]  e_dst;
   logic [63:0] e_alu, e_data;
   logic [31:0] e_pc;

   // entry held by the stage, as the model sees it
   logic        cur_valid, cur_mreq, cur_ld, cur_we, cur_got;

   logic        chk_en;
   logic        exp_out_valid, exp_allowin;
   logic [1:0]  exp_fwd;
   logic        hold32, hold64;
   logic [69:0]  prev32;
   logic [101:0] prev64;

   task automatic check(input string nm, input logic [101:0] act, input logic [101:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] ld_model(input logic [63:0] data, input logic [63:0] addr,
                                            input logic [1:0] sz, input logic sg, input int unsigned w);
      int unsigned nb, off;
      logic [63:0] v;
      nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd3 && w == 64) ? 8 : 4;
      off = (w == 64) ? int'(addr[2:0]) : int'(addr[1:0]);
      v   = '0;
      for (int unsigned i = 0; i < nb; i++) v[8*i +: 8] = data[8*(off+i) +: 8];
      if (sg && v[8*nb-1]) begin
         for (int unsigned b = 8*nb; b < 64; b++) v[b] = 1'b1;
      end
      if (w == 32) v[63:32] = '0;
      return v;
   endfunction

   function automatic int n_cancelled();
      int n = 0;
      foreach (resp_q[i]) if (resp_q[i].cancelled) n++;
      return n;
   endfunction

   task automatic set_entry(input logic mreq, input logic ld, input logic [1:0] sz, input logic sg,
                            input logic we, input logic [4:0] dst, input logic [63:0] alu,
                            input logic [63:0] data);
      e_valid = 1'b1; e_mreq = mreq; e_ld = ld; e_sz = sz; e_sg = sg; e_we = we;
      e_dst = dst; e_alu = alu; e_data = data; e_pc = $urandom; e_spare = 1'($urandom);
   endtask

   task automatic rand_entry();
      logic m, l;
      logic [1:0] s;
      logic [63:0] a;
      m = 1'($urandom);
      l = m & 1'($urandom);
      s = 2'($urandom);
      a = {$urandom, $urandom};
      if (l) begin
         if (s == 2'd1) a[0] = 1'b0;
         if (s == 2'd2) a[1:0] = '0;
         if (s == 2'd3) a[2:0] = '0;
      end
      set_entry(m, l, s, 1'($urandom), 1'($urandom), 5'($urandom), a, {$urandom, $urandom});
   endtask

   task automatic cycle(input logic want_fl, input logic want_dok, input logic wsa);
      resp_t r;
      logic ready, fire, accept;
      logic [63:0] res64, res32;
      @(negedge clk);
      data_ok = 1'b0;
      rdata64 = {$urandom, $urandom};
      if (want_dok && resp_q.size() > 0) begin
         r = resp_q.pop_front();
         data_ok = 1'b1;
         rdata64 = r.data;
         if (!r.cancelled) cur_got = 1'b1;
      end
      flush = want_fl && (n_cancelled() < 3);
      ws_allowin = wsa;
      es_to_ms_valid = e_valid;
      es_bus64 = {e_spare, e_mreq, e_ld, e_sz, e_sg, e_we, e_dst, e_alu, e_pc};
      es_bus32 = {e_spare, e_mreq, e_ld, e_sz, e_sg, e_we, e_dst, e_alu[31:0], e_pc};
      #1;
      ready         = cur_valid && (!cur_mreq || cur_got);
      exp_out_valid = ready && !flush;
      exp_allowin   = !cur_valid || (ready && wsa);
      exp_fwd       = {cur_valid && cur_we, cur_valid && cur_we && cur_ld && !ready};
      chk_en        = 1'b1;
      fire          = exp_out_valid && wsa;
      accept        = e_valid && exp_allowin && !flush;
      if (flush) begin
         if (cur_valid) begin
            // its response is still on the way and must be swallowed by the stage
            if (cur_mreq && !cur_got && resp_q.size() > 0) begin
               r = resp_q.pop_back();
               r.cancelled = 1'b1;
               resp_q.push_back(r);
            end
            if (q32.size() > 0) void'(q32.pop_back());
            if (q64.size() > 0) void'(q64.pop_back());
         end
         cur_valid = 1'b0;
      end else if (fire) begin
         cur_valid = 1'b0;
      end
      if (accept) begin
         if (e_mreq) begin
            r.data = e_data;
            r.cancelled = 1'b0;
            resp_q.push_back(r);
         end
         res64 = e_ld ? ld_model(e_data, e_alu, e_sz, e_sg, 64) : e_alu;
         res32 = e_ld ? ld_model({32'b0, e_data[31:0]}, e_alu, e_sz, e_sg, 32) : {32'b0, e_alu[31:0]};
         q32.push_back({e_we, e_dst, res32[31:0], e_pc});
         q64.push_back({e_we, e_dst, res64, e_pc});
         cur_valid = 1'b1; cur_mreq = e_mreq; cur_ld = e_ld; cur_we = e_we; cur_got = 1'b0;
         e_valid = 1'b0;
      end
   endtask

   always @(negedge clk) begin
      #3;
      if (chk_en) begin
         check("out_valid32", 102'(valid32), 102'(exp_out_valid));
         check("out_valid64", 102'(valid64), 102'(exp_out_valid));
         check("allowin32", 102'(allowin32), 102'(exp_allowin));
         check("allowin64", 102'(allowin64), 102'(exp_allowin));
         check("fwd_flags32", 102'(fwd32[38:37]), 102'(exp_fwd));
         check("fwd_flags64", 102'(fwd64[70:69]), 102'(exp_fwd));
         if (hold32 && valid32) check("hold_bus32", 102'(ws_bus32), 102'(prev32));
         if (hold64 && valid64) check("hold_bus64", 102'(ws_bus64), prev64);
         if (valid32 && ws_allowin) begin
            if (q32.size() == 0) check("spurious32", 102'(valid32), 102'(0));
            else check("bus32", 102'(ws_bus32), 102'(q32.pop_front()));
         end
         if (valid64 && ws_allowin) begin
            if (q64.size() == 0) check("spurious64", 102'(valid64), 102'(0));
            else check("bus64", ws_bus64, q64.pop_front());
         end
         hold32 = valid32 && !ws_allowin;
         hold64 = valid64 && !ws_allowin;
         prev32 = ws_bus32;
         prev64 = ws_bus64;
      end else begin
         hold32 = 1'b0;
         hold64 = 1'b0;
      end
   end

   initial begin
      chk_en = 1'b0; hold32 = 1'b0; hold64 = 1'b0;
      e_valid = 1'b0; e_mreq = 1'b0; e_ld = 1'b0; e_sg = 1'b0; e_we = 1'b0; e_spare = 1'b0;
      e_sz = '0; e_dst = '0; e_alu = '0; e_data = '0; e_pc = '0;
      cur_valid = 1'b0; cur_mreq = 1'b0; cur_ld = 1'b0; cur_we = 1'b0; cur_got = 1'b0;
      reset = 1'b1; ws_allowin = 1'b1; es_to_ms_valid = 1'b1; flush = 1'b1; data_ok = 1'b1;
      es_bus32 = '1; es_bus64 = '1; rdata64 = '1;
      repeat (3) @(negedge clk);
      reset = 1'b0; es_to_ms_valid = 1'b0; flush = 1'b0; data_ok = 1'b0;

      cycle(1'b0, 1'b0, 1'b1);

      // ALU op, dest 5
      set_entry(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 5'd5, 64'h1234, 64'h0);
      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1);

      // lb / lbu at byte 3
      set_entry(1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 5'd7, 64'h1003, 64'h0000_0000_80FF_FF00);
      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b1);
      set_entry(1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 5'd8, 64'h1003, 64'h0000_0000_80FF_FF00);
      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b1);

      // late response
      set_entry(1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 5'd9, 64'h2000, 64'hDEAD_BEEF_CAFE_F00D);
      cycle(1'b0, 1'b0, 1'b1);
      repeat (3) cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b1);

      // response while WB stalled
      set_entry(1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 5'd10, 64'h3006, 64'h1234_5678_9ABC_DEF0);
      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b1);

      // flush in WAIT, then a new load sees two responses
      set_entry(1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 5'd11, 64'h4000, 64'h1111_1111_1111_1111);
      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 1'b1);
      set_entry(1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 5'd12, 64'h4004, 64'h2222_3333_4444_5555);
      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b1);
      cycle(1'b0, 1'b1, 1'b1);

      // ld_size 11
      set_entry(1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 5'd13, 64'h5000, 64'h8000_0000_0000_0001);
      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b1);

      for (int unsigned n = 0; n < 4000; n++) begin
         if (!e_valid && ($urandom_range(0, 2) != 0)) rand_entry();
         cycle(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) != 0));
      end
      e_valid = 1'b0;
      repeat (12) cycle(1'b0, 1'b1, 1'b1);

      @(negedge clk);
      chk_en = 1'b0;
      check("drain32", 102'(q32.size()), 102'(0));
      check("drain64", 102'(q64.size()), 102'(0));
      check("drain_resp", 102'(resp_q.size()), 102'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning GPR/data width; legal values are 32 and 64.
REQ-002 SHALL have parameter ES_TO_MS_WD, default DATA_W+44, meaning input bus width.
REQ-003 SHALL have parameter MS_TO_WS_WD, default DATA_W+38, meaning output bus width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port ws_allowin, input, 1 bit: WB stage can accept an entry.
REQ-007 SHALL have port ms_allowin, output, 1 bit: MEM stage can accept an entry.
REQ-008 SHALL have port es_to_ms_valid, input, 1 bit: EX offers an entry.
REQ-009 SHALL have port es_to_ms_bus, input, ES_TO_MS_WD bits: {mem_req, ld_en, ld_size[1:0], ld_sign, gr_we, dest[4:0], alu_result[DATA_W-1:0], pc[31:0]}, MSB first, plus 1 spare bit at the MSB.
REQ-010 SHALL have port flush, input, 1 bit: cancel the held entry (exception/branch).
REQ-011 SHALL have port data_sram_data_ok, input, 1 bit: response for the oldest outstanding request.
REQ-012 SHALL have port data_sram_rdata, input, DATA_W bits: response data.
REQ-013 SHALL have port ms_to_ws_valid, output, 1 bit: entry offered to WB.
REQ-014 SHALL have port ms_to_ws_bus, output, MS_TO_WS_WD bits: {gr_we, dest, final_result, pc}.
REQ-015 SHALL have port ms_fwd_bus, output, DATA_W+7 bits: {fwd_valid, fwd_busy, dest, final_result} for ID/EX forwarding.

Function
REQ-016 SHALL latch es_to_ms_bus into the stage register when es_to_ms_valid && ms_allowin && !flush.
REQ-017 SHALL set ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
REQ-018 SHALL drive ms_ready_go = 1 when mem_req=0, or when the response is captured (buffered or arriving this cycle).
REQ-019 SHALL use a 2-state FSM: WAIT (mem_req entry, no data yet) and HAVE (data_ok seen or no request); entering with mem_req=1 goes to WAIT, and data_ok in WAIT goes to HAVE.
REQ-020 SHALL capture data_sram_rdata into a DATA_W buffer on data_ok when the stage cannot advance that cycle (ws_allowin=0), and use the buffer thereafter until the entry leaves.
REQ-021 SHALL extract load data by ld_size: 00 byte, 01 half, 10 word, 11 dword (only when DATA_W=64; when DATA_W=32, 11 is treated as word); lane selected by alu_result low bits, little-endian.
REQ-022 SHALL sign-extend the load result when ld_sign=1 and zero-extend it otherwise, to DATA_W.
REQ-023 SHALL set final_result = extracted load data if ld_en, else alu_result (stores pass alu_result).
REQ-024 SHALL set fwd_valid = ms_valid && gr_we, and fwd_busy = fwd_valid && ld_en && !ms_ready_go.
REQ-025 SHALL, on flush, clear ms_valid next cycle; if the flushed entry is in WAIT, increment a 2-bit discard counter.
REQ-026 SHALL, while discard counter ≠ 0, treat data_ok as belonging to a cancelled request: decrement the counter and neither capture the data nor advance the FSM.
REQ-027 SHALL, for simultaneous flush and data_ok in WAIT, count no discard; the data is dropped.
REQ-028 SHALL, for simultaneous data_ok and a discard counter decrement with a new entry in WAIT, apply the response to the discard only.
REQ-029 SHALL hold ms_to_ws_bus stable while ms_to_ws_valid=1 and ws_allowin=0.
REQ-030 SHALL have ms_to_ws_valid = ms_valid && ms_ready_go && !flush.

Reset
REQ-031 SHALL, on reset, clear ms_valid, set the FSM to HAVE, clear the discard counter and clear the data buffer to 0; ms_to_ws_valid=0, fwd_valid=0, fwd_busy=0, ms_allowin=1.
REQ-032 SHALL let reset override flush, data_ok and all handshakes in the same cycle; an outstanding request at reset is not tracked.

Verification
REQ-033 SHALL be verified with this stimulus: ALU entry, dest=5, alu_result=0x1234, ws_allowin=1. Required response: ms_to_ws_valid one cycle after acceptance, with final_result=0x1234.
REQ-034 SHALL be verified with this stimulus: lb at addr 0x..03, sign=1, rdata=0x80FF_FF00. Required response: final_result=0xFFFF_FF80; lbu gives 0x0000_0080.
REQ-035 SHALL be verified with this stimulus: load, with data_ok delayed 3 cycles. Required response: fwd_busy=1 and ms_ready_go=0 for 3 cycles, then valid with correct data.
REQ-036 SHALL be verified with this stimulus: data_ok while ws_allowin=0, then ws_allowin=1 after 2 cycles. Required response: the buffered data is delivered unchanged.
REQ-037 SHALL be verified with this stimulus: flush in WAIT, then a new load enters and two data_ok pulses arrive. Required response: the first data_ok is discarded and the second completes the new load.
REQ-038 SHALL be verified with this stimulus: DATA_W=64, ld_size=11, rdata=0x8000_0000_0000_0001. Required response: final_result equals rdata.
